// File: rtl/baw_pkg.sv
// Shared types and constants for the Black-and-White round sequencer.
// State encodings, comparator result codes, card count and card index width.
package baw_pkg;

    localparam int N_CARDS = 9;
    localparam int CARD_W  = 4;
    localparam logic [CARD_W-1:0] ROUND_MAX = CARD_W'(N_CARDS);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_SEL   = 3'd1,
        ST_FOLLOW_SEL = 3'd2,
        ST_REVEAL     = 3'd3,
        ST_SCORE      = 3'd4,
        ST_CHECK      = 3'd5,
        ST_GAME_OVER  = 3'd6
    } state_t;

    localparam logic [1:0] MR_DRAW   = 2'b00;
    localparam logic [1:0] MR_P1_WIN = 2'b01;
    localparam logic [1:0] MR_P2_WIN = 2'b10;

endpackage

// File: rtl/baw_card_validator.sv
// Combinational card check: a selection is playable when it is one-hot and held.
// Also reports the lowest-index card still held, used for auto-play.
module baw_card_validator
    import baw_pkg::*;
(
    input  logic [N_CARDS-1:0] sw_sel,
    input  logic [N_CARDS-1:0] hand,
    output logic               valid,
    output logic [CARD_W-1:0]  index,
    output logic [CARD_W-1:0]  lowest_held
);

    logic one_hot;

    always_comb begin
        index       = '0;
        lowest_held = '0;
        // Descending scan so the lowest held card is the last one written.
        for (int i = N_CARDS - 1; i >= 0; i--) begin
            if (hand[i])   lowest_held = CARD_W'(i);
            if (sw_sel[i]) index       = CARD_W'(i);
        end
        one_hot = (sw_sel != '0) && ((sw_sel & (sw_sel - 1'b1)) == '0);
        valid   = one_hot && ((sw_sel & hand) != '0);
    end

endmodule

// File: rtl/baw_round_sequencer.sv
// Black-and-White game sequencer: lead/follow card selection, reveal, score pulse, end check.
// Optional selection timeout with auto-play of the lowest held card: BAW_SEL_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for btn_start after reset
// LEAD_SEL   | match leader selects and confirms a card
// FOLLOW_SEL | other player selects and confirms a card
// REVEAL     | both cards held stable for the comparator, wait for btn_next
// SCORE      | one-cycle score_pulse, round count and leader update
// CHECK      | finish or all cards played -> GAME_OVER, else next match
// GAME_OVER  | game finished, btn_start begins a new one
module baw_round_sequencer
    import baw_pkg::*;
#(
`ifdef BAW_SEL_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_start,
    input  logic                btn_confirm,
    input  logic                btn_next,
    input  logic [N_CARDS-1:0]  sw_sel,
    input  logic [1:0]          match_result,
    input  logic                finish,
    output logic [2:0]          state_o,
    output logic                active_p2,
    output logic                lead_p2,
    output logic [N_CARDS-1:0]  p1_hand,
    output logic [N_CARDS-1:0]  p2_hand,
    output logic [CARD_W-1:0]   p1_card,
    output logic [CARD_W-1:0]   p2_card,
    output logic [CARD_W-1:0]   round_o,
    output logic                score_pulse,
    output logic                sel_error
);

    state_t               state;
    logic [N_CARDS-1:0]   active_hand;
    logic                 sel_valid;
    logic [CARD_W-1:0]    sel_index;
    logic [CARD_W-1:0]    lowest_held;
    logic                 in_sel;
    logic                 timeout;
    logic                 play;
    logic [CARD_W-1:0]    play_idx;
    logic [N_CARDS-1:0]   play_mask;

    assign state_o     = state;
    assign active_hand = active_p2 ? p2_hand : p1_hand;
    assign in_sel      = (state == ST_LEAD_SEL) || (state == ST_FOLLOW_SEL);

    baw_card_validator u_validator (
        .sw_sel      (sw_sel),
        .hand        (active_hand),
        .valid       (sel_valid),
        .index       (sel_index),
        .lowest_held (lowest_held)
    );

`ifdef BAW_SEL_TIMEOUT_EN
    localparam logic [31:0] SEL_LOAD = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] sel_cnt;

    assign timeout = in_sel && (sel_cnt == '0);

    // Reloaded on every confirm and on every selection entry; expires at terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sel_cnt <= SEL_LOAD;
        else if (!in_sel || btn_confirm || timeout)
            sel_cnt <= SEL_LOAD;
        else
            sel_cnt <= sel_cnt - 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        play     = in_sel && btn_confirm && sel_valid;
        play_idx = sel_index;
        if (in_sel && !play && timeout) begin
            play     = 1'b1;
            play_idx = lowest_held;
        end
        play_mask = N_CARDS'(1) << play_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            active_p2   <= 1'b0;
            lead_p2     <= 1'b0;
            p1_hand     <= '1;
            p2_hand     <= '1;
            p1_card     <= '0;
            p2_card     <= '0;
            round_o     <= '0;
            score_pulse <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            sel_error   <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (btn_start) begin
                        p1_hand   <= '1;
                        p2_hand   <= '1;
                        round_o   <= '0;
                        lead_p2   <= 1'b0;
                        active_p2 <= 1'b0;
                        state     <= ST_LEAD_SEL;
                    end
                end
                ST_LEAD_SEL, ST_FOLLOW_SEL: begin
                    if (play) begin
                        if (active_p2) begin
                            p2_card <= play_idx;
                            p2_hand <= p2_hand & ~play_mask;
                        end else begin
                            p1_card <= play_idx;
                            p1_hand <= p1_hand & ~play_mask;
                        end
                        if (state == ST_LEAD_SEL) begin
                            active_p2 <= ~lead_p2;
                            state     <= ST_FOLLOW_SEL;
                        end else begin
                            state     <= ST_REVEAL;
                        end
                    end else if (btn_confirm) begin
                        sel_error <= 1'b1;
                    end
                end
                ST_REVEAL: begin
                    if (btn_next) begin
                        score_pulse <= 1'b1;
                        state       <= ST_SCORE;
                    end
                end
                ST_SCORE: begin
                    if (round_o != ROUND_MAX)
                        round_o <= round_o + 1'b1;
                    if (match_result == MR_P1_WIN)
                        lead_p2 <= 1'b0;
                    else if (match_result == MR_P2_WIN)
                        lead_p2 <= 1'b1;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (finish || round_o == ROUND_MAX) begin
                        state <= ST_GAME_OVER;
                    end else begin
                        active_p2 <= lead_p2;
                        state     <= ST_LEAD_SEL;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_baw_round_sequencer.sv
// Directed bench for baw_round_sequencer; define BAW_SEL_TIMEOUT_EN to also cover auto-play.
module tb_baw_round_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_LEAD = 3'd1, S_FOLLOW = 3'd2,
                           S_REVEAL = 3'd3, S_SCORE = 3'd4, S_CHECK = 3'd5, S_OVER = 3'd6;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start = 1'b0, btn_confirm = 1'b0, btn_next = 1'b0;
    logic [8:0] sw_sel = '0;
    logic [1:0] match_result = 2'b00;
    logic       finish = 1'b0;
    logic [2:0] state_o;
    logic       active_p2, lead_p2, score_pulse, sel_error;
    logic [8:0] p1_hand, p2_hand;
    logic [3:0] p1_card, p2_card, round_o;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

`ifdef BAW_SEL_TIMEOUT_EN
    baw_round_sequencer #(.TIMEOUT_CYCLES(16)) dut (
`else
    baw_round_sequencer dut (
`endif
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_confirm(btn_confirm),
        .btn_next(btn_next), .sw_sel(sw_sel), .match_result(match_result), .finish(finish),
        .state_o(state_o), .active_p2(active_p2), .lead_p2(lead_p2), .p1_hand(p1_hand),
        .p2_hand(p2_hand), .p1_card(p1_card), .p2_card(p2_card), .round_o(round_o),
        .score_pulse(score_pulse), .sel_error(sel_error));

    always @(negedge clk) if (score_pulse) pulse_cnt++;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0 = start, 1 = confirm, 2 = next; returns at the negedge after the consuming edge
    task automatic press(input int b);
        @(negedge clk);
        btn_start = (b == 0); btn_confirm = (b == 1); btn_next = (b == 2);
        @(negedge clk);
        btn_start = 1'b0; btn_confirm = 1'b0; btn_next = 1'b0;
    endtask

    task automatic confirm(input logic [8:0] sw);
        sw_sel = sw;
        press(1);
    endtask

    // leader card, follower card, comparator result, finish; ends in LEAD_SEL or GAME_OVER
    task automatic play_match(input logic [8:0] lead_sw, input logic [8:0] follow_sw,
                              input logic [1:0] mr, input logic fin);
        confirm(lead_sw);
        confirm(follow_sw);
        match_result = mr;
        finish = fin;
        press(2);
        @(negedge clk);
        @(negedge clk);
        finish = 1'b0;
    endtask

    initial begin
        logic [8:0] s;
        int pc;
        reset = 1'b1;
        #12;
        chk("rst_state", 16'(state_o), 16'(S_IDLE));
        chk("rst_p1_hand", 16'(p1_hand), 16'h1FF);
        chk("rst_p2_hand", 16'(p2_hand), 16'h1FF);
        chk("rst_cards", {8'(p1_card), 8'(p2_card)}, 16'h0);
        chk("rst_round", 16'(round_o), 16'h0);
        chk("rst_flags", 16'({lead_p2, active_p2, score_pulse, sel_error}), 16'h0);
        @(negedge clk);
        reset = 1'b0;

        press(0);
        chk("start_state", 16'(state_o), 16'(S_LEAD));
        chk("start_active", 16'(active_p2), 16'h0);
        confirm(9'h001);
        chk("m1_lead_state", 16'(state_o), 16'(S_FOLLOW));
        chk("m1_p1_card", 16'(p1_card), 16'h0);
        chk("m1_p1_hand", 16'(p1_hand), 16'h1FE);
        chk("m1_active_follow", 16'(active_p2), 16'h1);
        confirm(9'h002);
        chk("m1_reveal", 16'(state_o), 16'(S_REVEAL));
        chk("m1_p2_card", 16'(p2_card), 16'h1);
        chk("m1_p2_hand", 16'(p2_hand), 16'h1FD);
        match_result = 2'b00;
        press(2);
        chk("m1_score_state", 16'(state_o), 16'(S_SCORE));
        chk("m1_score_pulse", 16'(score_pulse), 16'h1);
        @(negedge clk);
        chk("m1_check_state", 16'(state_o), 16'(S_CHECK));
        chk("m1_round", 16'(round_o), 16'h1);
        @(negedge clk);
        chk("m1_next_lead", 16'(state_o), 16'(S_LEAD));
        chk("m1_pulse_cnt", 16'(pulse_cnt), 16'h1);
        chk("m1_draw_keeps_lead", 16'({lead_p2, active_p2}), 16'h0);

        confirm(9'h003);
        chk("err_two_hot", 16'(sel_error), 16'h1);
        confirm(9'h000);
        chk("err_zero", 16'(sel_error), 16'h1);
        confirm(9'h001);
        chk("err_replay", 16'(sel_error), 16'h1);
        chk("err_state", 16'(state_o), 16'(S_LEAD));
        chk("err_hands", {7'h0, p1_hand}, 16'h1FE);
        chk("err_hands_p2", {7'h0, p2_hand}, 16'h1FD);

        play_match(9'h004, 9'h001, 2'b10, 1'b0);
        chk("m2_p2_wins_lead", 16'({lead_p2, active_p2}), 16'h3);
        chk("m2_cards", {8'(p1_card), 8'(p2_card)}, 16'h0200);
        chk("m2_round", 16'(round_o), 16'h2);
        play_match(9'h004, 9'h002, 2'b00, 1'b0);
        chk("m3_draw_keeps_p2", 16'({lead_p2, active_p2}), 16'h3);
        chk("m3_cards", {8'(p1_card), 8'(p2_card)}, 16'h0102);
        chk("m3_hands", {7'h0, p1_hand & p2_hand}, 16'h1F8);

        for (int m = 3; m < 9; m++) begin
            s = 9'(1) << m;
            play_match(s, s, 2'b00, 1'b0);
            chk("mloop_p1_card", 16'(p1_card), 16'(m));
            chk("mloop_round", 16'(round_o), 16'(m + 1));
        end
        chk("end_state", 16'(state_o), 16'(S_OVER));
        chk("end_round", 16'(round_o), 16'h9);
        chk("end_hands", {7'h0, p1_hand | p2_hand}, 16'h0);
        chk("end_pulses", 16'(pulse_cnt), 16'h9);
        press(2);
        chk("over_ignores_next", 16'(state_o), 16'(S_OVER));

        press(0);
        chk("restart_state", 16'(state_o), 16'(S_LEAD));
        chk("restart_hands", {7'h0, p1_hand & p2_hand}, 16'h1FF);
        chk("restart_round", 16'(round_o), 16'h0);
        play_match(9'h001, 9'h001, 2'b01, 1'b1);
        chk("finish_over", 16'(state_o), 16'(S_OVER));
        chk("finish_round", 16'(round_o), 16'h1);

        press(0);
        confirm(9'h001);
        chk("mid_follow", 16'(state_o), 16'(S_FOLLOW));
        pc = pulse_cnt;
        #2 reset = 1'b1;
        #1;
        chk("arst_state", 16'(state_o), 16'(S_IDLE));
        chk("arst_hands", {7'h0, p1_hand & p2_hand}, 16'h1FF);
        chk("arst_card", 16'(p1_card), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_no_pulse", 16'(pulse_cnt), 16'(pc));

`ifdef BAW_SEL_TIMEOUT_EN
        begin
            int n;
            press(0);
            for (int i = 0; i < 3; i++) begin
                s = 9'(1) << i;
                play_match(s, s, 2'b00, 1'b0);
            end
            chk("to_p1_hand_pre", {7'h0, p1_hand}, 16'h1F8);
            n = 0;
            while (state_o == S_LEAD && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("to_cycles", 16'(n), 16'd16);
            chk("to_state", 16'(state_o), 16'(S_FOLLOW));
            chk("to_p1_card", 16'(p1_card), 16'h3);
            chk("to_p1_hand", {7'h0, p1_hand}, 16'h1F0);
            #2 reset = 1'b1;
            #1;
            chk("to_arst_state", 16'(state_o), 16'(S_IDLE));
            chk("to_arst_hands", {7'h0, p1_hand & p2_hand}, 16'h1FF);
            @(negedge clk);
            reset = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
